// File: rtl/counter_limit_if.sv
// Control and status bundle for counter_limit: the controller drives the
// count controls and limit, the counter returns its count and flags.
interface counter_limit_if #(
   parameter int WIDTH = 5
);
   logic             clear;
   logic             load;
   logic [WIDTH-1:0] load_value;
   logic             increment;
   logic             decrement;
   logic [WIDTH-1:0] limit;
   logic [WIDTH-1:0] count;
   logic             at_zero;
   logic             at_limit;
   logic             wrapped;
   logic             overflow;

   modport master (
      output clear, load, load_value, increment, decrement, limit,
      input  count, at_zero, at_limit, wrapped, overflow
   );

   modport slave (
      input  clear, load, load_value, increment, decrement, limit,
      output count, at_zero, at_limit, wrapped, overflow
   );
endinterface

// File: rtl/counter_limit.sv
// Up/down counter bounded by a runtime limit, with load, wrap-or-saturate
// behaviour at both boundaries, a one-cycle wrap pulse and a sticky overflow flag.
module counter_limit #(
   parameter int WIDTH    = 5,
   parameter bit SATURATE = 1'b0
) (
   input logic             clk,
   input logic             reset,
   counter_limit_if.slave  bus
);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;
   logic             wrapped_q;
   logic             wrapped_d;
   logic             overflow_q;

   // NOTE: every signal gets its hold value first so no path through the
   // if/else chain can leave it unassigned and infer a latch.
   always_comb begin
      count_d   = count_q;
      wrapped_d = 1'b0;
      if (bus.load) begin
         count_d = (bus.load_value > bus.limit) ? bus.limit : bus.load_value;
      end else if (bus.increment && bus.decrement) begin
         count_d = count_q;
      end else if (bus.increment) begin
         // Also the path taken when the limit was lowered below the count.
         if (count_q < bus.limit) begin
            count_d = count_q + ONE;
         end else begin
            count_d   = SATURATE ? bus.limit : '0;
            wrapped_d = 1'b1;
         end
      end else if (bus.decrement) begin
         if (count_q != '0) begin
            count_d = count_q - ONE;
         end else begin
            count_d   = SATURATE ? '0 : bus.limit;
            wrapped_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (reset || bus.clear) begin
         count_q    <= '0;
         wrapped_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wrapped_q  <= wrapped_d;
         overflow_q <= overflow_q | wrapped_d;
      end
   end

   assign bus.count    = count_q;
   assign bus.wrapped  = wrapped_q;
   assign bus.overflow = overflow_q;
   assign bus.at_zero  = (count_q == '0);
   assign bus.at_limit = (count_q >= bus.limit);
endmodule

// File: tb/tb_counter_limit.sv
// Self-checking bench: a wrapping and a saturating counter share stimulus;
// a behavioural model pushes expectations into a scoreboard popped after each edge.
module tb_counter_limit;
   typedef struct {
      bit reset;
      bit clear;
      bit load;
      bit increment;
      bit decrement;
      int load_value;
      int limit;
   } ctrl_t;

   typedef struct {
      int         dut;
      logic [4:0] count;
      logic       at_zero;
      logic       at_limit;
      logic       wrapped;
      logic       overflow;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   int   m_cnt[2];
   bit   m_ov[2];

   counter_limit_if #(.WIDTH(5)) w_if ();
   counter_limit_if #(.WIDTH(5)) s_if ();

   counter_limit #(.WIDTH(5), .SATURATE(1'b0)) u_wrap (
      .clk(clk), .reset(reset), .bus(w_if.slave)
   );
   counter_limit #(.WIDTH(5), .SATURATE(1'b1)) u_sat (
      .clk(clk), .reset(reset), .bus(s_if.slave)
   );

   always #5 clk = ~clk;

   function automatic ctrl_t idle(input int limit);
      ctrl_t c;
      c = '{default: 0};
      c.limit = limit;
      return c;
   endfunction

   // Reference behaviour written from the rule table, one edge at a time.
   function automatic void model_step(input bit sat, input ctrl_t c,
                                      inout int cnt, inout bit ov, output bit wr);
      wr = 1'b0;
      if (c.reset || c.clear) begin
         cnt = 0;
         ov  = 1'b0;
         return;
      end
      if (c.load) begin
         cnt = (c.load_value < c.limit) ? c.load_value : c.limit;
      end else if (c.increment && !c.decrement) begin
         if (cnt >= c.limit) begin
            wr  = 1'b1;
            cnt = sat ? c.limit : 0;
         end else begin
            cnt = cnt + 1;
         end
      end else if (c.decrement && !c.increment) begin
         if (cnt == 0) begin
            wr  = 1'b1;
            cnt = sat ? 0 : c.limit;
         end else begin
            cnt = cnt - 1;
         end
      end
      ov = ov | wr;
   endfunction

   task automatic step(input ctrl_t c, input string name);
      exp_t       e;
      bit         wr;
      logic [4:0] a_cnt;
      logic       a_z, a_l, a_w, a_o;
      @(negedge clk);
      reset = c.reset;
      w_if.clear = c.clear;  s_if.clear = c.clear;
      w_if.load  = c.load;   s_if.load  = c.load;
      w_if.increment = c.increment;  s_if.increment = c.increment;
      w_if.decrement = c.decrement;  s_if.decrement = c.decrement;
      w_if.load_value = 5'(c.load_value);  s_if.load_value = 5'(c.load_value);
      w_if.limit = 5'(c.limit);  s_if.limit = 5'(c.limit);
      for (int d = 0; d < 2; d++) begin
         model_step(d == 1, c, m_cnt[d], m_ov[d], wr);
         e.dut      = d;
         e.count    = 5'(m_cnt[d]);
         e.at_zero  = (m_cnt[d] == 0);
         e.at_limit = (m_cnt[d] >= c.limit);
         e.wrapped  = wr;
         e.overflow = m_ov[d];
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e     = sb.pop_front();
         a_cnt = e.dut ? s_if.count    : w_if.count;
         a_z   = e.dut ? s_if.at_zero  : w_if.at_zero;
         a_l   = e.dut ? s_if.at_limit : w_if.at_limit;
         a_w   = e.dut ? s_if.wrapped  : w_if.wrapped;
         a_o   = e.dut ? s_if.overflow : w_if.overflow;
         checks += 5;
         if (a_cnt !== e.count) begin
            failures++;
            $display("FAIL %s dut%0d count got=%0d exp=%0d", name, e.dut, a_cnt, e.count);
         end
         if (a_z !== e.at_zero) begin
            failures++;
            $display("FAIL %s dut%0d at_zero got=%b exp=%b", name, e.dut, a_z, e.at_zero);
         end
         if (a_l !== e.at_limit) begin
            failures++;
            $display("FAIL %s dut%0d at_limit got=%b exp=%b", name, e.dut, a_l, e.at_limit);
         end
         if (a_w !== e.wrapped) begin
            failures++;
            $display("FAIL %s dut%0d wrapped got=%b exp=%b", name, e.dut, a_w, e.wrapped);
         end
         if (a_o !== e.overflow) begin
            failures++;
            $display("FAIL %s dut%0d overflow got=%b exp=%b", name, e.dut, a_o, e.overflow);
         end
      end
   endtask

   task automatic test_reset();
      ctrl_t c;
      c = idle(3);
      c.reset = 1'b1;
      c.increment = 1'b1;
      step(c, "reset1");
      step(c, "reset2");
      checks++;
      if ({w_if.count, w_if.at_zero, w_if.wrapped, w_if.overflow} !== {5'd0, 1'b1, 1'b0, 1'b0}) begin
         failures++;
         $display("FAIL reset_const got cnt=%0d z=%b w=%b o=%b exp cnt=0 z=1 w=0 o=0",
                  w_if.count, w_if.at_zero, w_if.wrapped, w_if.overflow);
      end
   endtask

   task automatic test_wrap_up();
      ctrl_t c;
      int exp_cnt[4] = '{1, 2, 3, 0};
      c = idle(3);
      c.increment = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step(c, "wrap_up");
         checks++;
         if (w_if.count !== 5'(exp_cnt[i]) || w_if.wrapped !== (i == 3)) begin
            failures++;
            $display("FAIL wrap_up_const edge%0d got cnt=%0d w=%b exp cnt=%0d w=%b",
                     i, w_if.count, w_if.wrapped, exp_cnt[i], (i == 3));
         end
      end
      step(idle(3), "wrap_up_hold");
      checks++;
      if (w_if.overflow !== 1'b1) begin
         failures++;
         $display("FAIL overflow_sticky got=%b exp=1", w_if.overflow);
      end
      c = idle(3);
      c.clear = 1'b1;
      step(c, "wrap_up_clear");
   endtask

   task automatic test_saturate();
      ctrl_t c;
      c = idle(31);
      c.load = 1'b1;
      c.load_value = 31;
      step(c, "sat_load");
      c = idle(31);
      c.increment = 1'b1;
      step(c, "sat_inc_top");
      checks++;
      if (s_if.count !== 5'd31 || s_if.wrapped !== 1'b1) begin
         failures++;
         $display("FAIL sat_top_const got cnt=%0d w=%b exp cnt=31 w=1", s_if.count, s_if.wrapped);
      end
      step(idle(31), "sat_pulse_end");
      c = idle(31);
      c.clear = 1'b1;
      step(c, "sat_clear");
      c = idle(31);
      c.decrement = 1'b1;
      step(c, "sat_dec_zero");
      checks++;
      if (s_if.count !== 5'd0 || s_if.wrapped !== 1'b1) begin
         failures++;
         $display("FAIL sat_zero_const got cnt=%0d w=%b exp cnt=0 w=1", s_if.count, s_if.wrapped);
      end
   endtask

   task automatic test_wrap_down();
      ctrl_t c;
      c = idle(9);
      c.clear = 1'b1;
      step(c, "down_clear");
      c = idle(9);
      c.decrement = 1'b1;
      step(c, "down_dec_zero");
      checks++;
      if (w_if.count !== 5'd9 || w_if.wrapped !== 1'b1) begin
         failures++;
         $display("FAIL down_const got cnt=%0d w=%b exp cnt=9 w=1", w_if.count, w_if.wrapped);
      end
      c.increment = 1'b1;
      step(c, "down_inc_and_dec");
   endtask

   task automatic test_priority();
      ctrl_t c;
      c = idle(12);
      c.load = 1'b1;
      c.increment = 1'b1;
      c.load_value = 20;
      step(c, "prio_load_clamp");
      checks++;
      if (w_if.count !== 5'd12) begin
         failures++;
         $display("FAIL prio_clamp_const got=%0d exp=12", w_if.count);
      end
      c.clear = 1'b1;
      step(c, "prio_clear_over_load");
      c.clear = 1'b0;
      c.reset = 1'b1;
      c.decrement = 1'b1;
      step(c, "prio_reset_over_load");
   endtask

   task automatic test_limit_change();
      ctrl_t c;
      c = idle(31);
      c.load = 1'b1;
      c.load_value = 10;
      step(c, "lim_load10");
      step(idle(4), "lim_lowered");
      checks++;
      if (w_if.count !== 5'd10 || w_if.at_limit !== 1'b1) begin
         failures++;
         $display("FAIL lim_lowered_const got cnt=%0d al=%b exp cnt=10 al=1", w_if.count, w_if.at_limit);
      end
      c = idle(4);
      c.increment = 1'b1;
      step(c, "lim_inc_over");
      checks++;
      if (w_if.count !== 5'd0 || s_if.count !== 5'd4) begin
         failures++;
         $display("FAIL lim_inc_const got wrap=%0d sat=%0d exp wrap=0 sat=4", w_if.count, s_if.count);
      end
      // Limit of zero: count pinned at 0, every inc or dec pulses wrapped.
      c = idle(0);
      c.clear = 1'b1;
      step(c, "lim0_clear");
      c = idle(0);
      c.increment = 1'b1;
      step(c, "lim0_inc");
      c = idle(0);
      c.decrement = 1'b1;
      step(c, "lim0_dec");
   endtask

   task automatic test_back_to_back();
      ctrl_t c;
      int lim = 7;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 15) == 0) lim = $urandom_range(0, 31);
         c = idle(lim);
         c.reset      = ($urandom_range(0, 40) == 0);
         c.clear      = ($urandom_range(0, 30) == 0);
         c.load       = ($urandom_range(0, 10) == 0);
         c.increment  = ($urandom_range(0, 2) != 0);
         c.decrement  = ($urandom_range(0, 2) == 0);
         c.load_value = $urandom_range(0, 31);
         step(c, "random");
      end
   endtask

   initial begin
      reset = 1'b1;
      w_if.clear = 1'b0;  s_if.clear = 1'b0;
      w_if.load  = 1'b0;  s_if.load  = 1'b0;
      w_if.increment = 1'b0;  s_if.increment = 1'b0;
      w_if.decrement = 1'b0;  s_if.decrement = 1'b0;
      w_if.load_value = '0;  s_if.load_value = '0;
      w_if.limit = '0;  s_if.limit = '0;
      m_cnt = '{0, 0};
      m_ov  = '{0, 0};
      test_reset();
      test_wrap_up();
      test_saturate();
      test_wrap_down();
      test_priority();
      test_limit_change();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
